// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: ROB/CDB widths, the CDB packet type and the ROB age helper.
package cdb_arbiter_pkg;
  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 64;
  typedef struct packed {
    logic [ROB_TAG_W-1:0]  tag;
    logic [ROB_DATA_W-1:0] data;
  } cdb_pkt_t;
  // distance from the ROB head; the TAG_W-bit wrap is the mod ROB_DEPTH
  function automatic logic [ROB_TAG_W-1:0] age(input logic [ROB_TAG_W-1:0] tag,
                                               input logic [ROB_TAG_W-1:0] head);
    return tag - head;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// cdb_arbiter_rr_picker: one-hot grant to the first set request at or after i_ptr, wrapping.
module cdb_arbiter_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant = '0;
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
        o_idx = W'((int'(i_ptr) + k) % N);
      end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the single registered CDB/ROB write slot among NUM_REQ FUs.
// Define CDB_OLDEST_FIRST_EN to grant the request oldest relative to rob_head (ties round-robin).
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int DATA_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [TAG_W-1:0]          rob_head,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  input  logic                      cdb_ready
);
  import cdb_arbiter_pkg::*;
  localparam int PTR_W = $clog2(NUM_REQ);
  if (TAG_W != ROB_TAG_W || DATA_W != ROB_DATA_W || ROB_DEPTH != (1 << TAG_W)) begin : g_cfg_err
    $error("cdb_arbiter: parameters must match cdb_arbiter_pkg");
  end
  logic [TAG_W-1:0]   w_tag  [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand, w_grant;
  logic [PTR_W-1:0]   w_idx, r_rr_ptr;
  logic               w_load, w_dup, r_valid;
  cdb_pkt_t           r_slot;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_tag[i]  = req_tag[i*TAG_W +: TAG_W];
    assign w_data[i] = req_data[i*DATA_W +: DATA_W];
  end
`ifdef CDB_OLDEST_FIRST_EN
  logic [TAG_W-1:0] w_min_age;
  always_comb begin
    w_min_age = '1;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && age(w_tag[i], rob_head) < w_min_age) w_min_age = age(w_tag[i], rob_head);
  end
  // only the oldest requests reach the picker, so it resolves age ties round-robin
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) w_cand[i] = req_valid[i] && age(w_tag[i], rob_head) == w_min_age;
  end
`else
  logic w_unused_head;
  assign w_unused_head = ^rob_head;
  assign w_cand = req_valid;
`endif
  cdb_arbiter_rr_picker #(.N(NUM_REQ), .W(PTR_W)) u_picker (
    .i_req  (w_cand),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );
  assign w_load    = !flush && (!r_valid || cdb_ready);
  assign req_ready = (rst_n && w_load) ? w_grant : '0;
  assign cdb_valid = r_valid;
  assign cdb_tag   = r_slot.tag;
  assign cdb_data  = r_slot.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_slot   <= '0;
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= |w_grant;
      if (|w_grant) begin
        r_slot   <= '{tag: w_tag[w_idx], data: w_data[w_idx]};
        r_rr_ptr <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = i + 1; k < NUM_REQ; k++)
        if (req_valid[i] && req_valid[k] && w_tag[i] == w_tag[k]) w_dup = 1'b1;
  end
  a_no_dup_tag: assert property (@(posedge clk) disable iff (!rst_n) !w_dup)
    else $error("cdb_arbiter: two FUs present the same ROB tag");
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter; expected packets are queued when a grant is expected.
module tb_cdb_arbiter;
  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, cdb_ready = 1'b1;
  logic [2:0]   rob_head = '0;
  logic [3:0]   req_valid = '0, req_ready;
  logic [11:0]  req_tag = '0;
  logic [255:0] req_data = '0;
  logic         cdb_valid;
  logic [2:0]   cdb_tag;
  logic [63:0]  cdb_data;
  always #5 clk = ~clk;
  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ready(cdb_ready)
  );
  typedef struct packed {logic [2:0] tag; logic [63:0] data;} pkt_t;
  pkt_t sb[$];
  pkt_t held;
  int   checks = 0, failures = 0, m_ptr = 0;
  logic m_valid = 1'b0;
`ifdef CDB_OLDEST_FIRST_EN
  localparam bit OLDEST = 1'b1;
`else
  localparam bit OLDEST = 1'b0;
`endif
  function automatic logic [3:0] pick(input logic [3:0] v);
    int best = 99;
    logic [3:0] g = '0;
    for (int k = 0; k < 4; k++) begin
      int i, a;
      i = (m_ptr + k) % 4;
      a = (int'(req_tag[i*3 +: 3]) - int'(rob_head) + 8) % 8;
      if (v[i] && (OLDEST ? a < best : best == 99)) begin best = a; g = 4'b1 << i; end
    end
    return g;
  endfunction
  function automatic logic [3:0] predict();
    return (!flush && (!m_valid || cdb_ready)) ? pick(req_valid) : 4'b0;
  endfunction
  task automatic commit(input logic [3:0] g);
    for (int i = 0; i < 4; i++)
      if (g[i]) begin
        sb.push_back('{tag: req_tag[i*3 +: 3], data: req_data[i*64 +: 64]});
        m_ptr = (i + 1) % 4;
      end
    if (flush) m_valid = 1'b0;
    else if (!m_valid || cdb_ready) m_valid = |g;
    @(posedge clk); #1;
  endtask
  task automatic set_pkt(input int i, input logic [2:0] t, input logic [63:0] d);
    req_tag[i*3 +: 3] = t;
    req_data[i*64 +: 64] = d;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) set_pkt(i, 3'(i), 64'hC0DE_0000 + 64'(i));
    req_valid = 4'b1111;
    @(negedge clk);
    checks += 4;
    if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", cdb_valid); end
    if (cdb_tag !== 3'd0) begin failures++; $display("FAIL reset_tag got %0d want 0", cdb_tag); end
    if (cdb_data !== 64'd0) begin failures++; $display("FAIL reset_data got %h want 0", cdb_data); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL pre_reset_grant got %b want 0100", req_ready); end
    commit(4'b0100);
    req_valid = 4'b1111;
    cdb_ready = 1'b0;
    #2;
    checks++;
    if (cdb_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_slot got %b want 1", cdb_valid); end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (cdb_valid !== 1'b0) begin failures++; $display("FAIL midrun_reset_valid got %b want 0", cdb_valid); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL midrun_reset_ready got %b want 0000", req_ready); end
    sb.delete();
    m_valid = 1'b0;
    m_ptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cdb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_grant got %b want 0001", req_ready); end
    commit(4'b0001);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL post_reset_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    commit(predict());
  endtask
  task automatic test_single();
    set_pkt(0, 3'd5, 64'hDEAD);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got %b want 0001", req_ready); end
    commit(4'b0001);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_data !== 64'hDEAD) begin
      failures++; $display("FAIL single_slot got v=%b %0d/%h want 1 5/dead", cdb_valid, cdb_tag, cdb_data);
    end
    void'(sb.pop_front());
    commit(predict());
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_drain got %b want 0", cdb_valid); end
    commit(predict());
  endtask
  task automatic test_rr();
    logic [3:0] lit [5];
    if (OLDEST) lit = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    else lit = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) set_pkt(i, 3'(i + 1), 64'hA000 + 64'(i));
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL rr_prime got %b want 1000", req_ready); end
    commit(4'b1000);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
        failures++; $display("FAIL rr_slot%0d got v=%b %0d/%h want %0d/%h", k, cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
      end
      void'(sb.pop_front());
      if (req_ready !== lit[k]) begin failures++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, lit[k]); end
      commit(lit[k]);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL rr_last_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    commit(predict());
  endtask
  task automatic test_backpressure();
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_load got %b want 0001", req_ready); end
    commit(4'b0001);
    req_valid = 4'b0110;
    cdb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cdb_ready = 1'b1;
      @(negedge clk);
      if (k == 0) held = sb.pop_front();
      checks += 2;
      if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== held) begin
        failures++; $display("FAIL bp_hold%0d got v=%b %0d/%h want %0d/%h", k, cdb_valid, cdb_tag, cdb_data, held.tag, held.data);
      end
      if (req_ready !== (k == 3 ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL bp_ready%0d got %b want %b", k, req_ready, (k == 3 ? 4'b0010 : 4'b0000));
      end
      commit(k == 3 ? 4'b0010 : 4'b0000);
    end
    req_valid = 4'b0100;
    @(negedge clk);
    checks += 2;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL bp_fu1_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_fu2_grant got %b want 0100", req_ready); end
    commit(4'b0100);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL bp_fu2_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    commit(predict());
  endtask
  task automatic test_flush();
    logic [3:0] first;
    first = OLDEST ? 4'b0001 : 4'b1000;
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== first) begin failures++; $display("FAIL flush_setup got %b want %b", req_ready, first); end
    commit(first);
    flush = 1'b1;
    @(negedge clk);
    checks += 2;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL flush_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got %b want 0000", req_ready); end
    commit(4'b0000);
    flush = 1'b0;
    @(negedge clk);
    checks += 2;
    if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got %b want 0", cdb_valid); end
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL flush_ptr_held got %b want 0001", req_ready); end
    commit(4'b0001);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
      failures++; $display("FAIL flush_after_slot got v=%b %0d/%h want %0d/%h", cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
    end
    void'(sb.pop_front());
    commit(predict());
  endtask
  task automatic test_arbitration();
    logic [3:0] lit [4];
    if (OLDEST) lit = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};
    else lit = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rob_head = 3'd6;
    set_pkt(0, 3'd1, 64'hF0);
    set_pkt(1, 3'd7, 64'hF1);
    set_pkt(2, 3'd3, 64'hF2);
    set_pkt(3, 3'd6, 64'hF3);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (cdb_valid !== 1'b1 || {cdb_tag, cdb_data} !== sb[0]) begin
          failures++; $display("FAIL arb_slot%0d got v=%b %0d/%h want %0d/%h", k, cdb_valid, cdb_tag, cdb_data, sb[0].tag, sb[0].data);
        end
        void'(sb.pop_front());
      end
      if (k < 4) begin
        checks++;
        if (req_ready !== lit[k]) begin failures++; $display("FAIL arb_grant%0d got %b want %b", k, req_ready, lit[k]); end
        commit(lit[k]);
        req_valid = req_valid & ~lit[k];
      end
    end
    commit(predict());
    checks++;
    if (cdb_valid !== 1'b0) begin failures++; $display("FAIL arb_drain got %b want 0", cdb_valid); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_flush();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
